// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_bank storage block and its array.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  localparam int RD_LAT_MAX = 2;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port storage with byte-enable writes and a registered read port
// whose output is zero in any cycle that did not follow a read.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [be_width(DATA_W)-1:0] be_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic                        re_i,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int BE_W = be_width(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset; a reset would turn it into flops instead of a
  // RAM macro. Known contents come from the clear sweep driven by the top level.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= re_i ? mem[addr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// Parametrised RAM bank: clear-sweep FSM, user access arbitration, out-of-range
// filtering and a 1- or 2-stage read pipeline carrying valid plus data.
module ram_bank
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 32,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        cen,
  input  logic                        wen,
  input  logic [be_width(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           din,
  output logic                        ready,
  output logic                        rvalid,
  output logic [DATA_W-1:0]           dout
);

  localparam int                BE_W      = be_width(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_bank: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("ram_bank: DEPTH out of range for ADDR_W");
  end

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults are assigned before the case so no path leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  logic sweeping, accept, in_range, rd_accept;
  logic arr_we, arr_re;
  logic [BE_W-1:0]   arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  assign sweeping  = (state_q == ST_CLEAR);
  assign ready     = (state_q == ST_READY);
  assign accept    = ready & cen & ~clr;
  assign in_range  = {1'b0, addr} < DEPTH_L;
  assign rd_accept = accept & ~wen;

  // The sweep owns the array port while clearing; user accesses never overlap it.
  assign arr_we    = sweeping | (accept & wen & in_range);
  assign arr_re    = rd_accept & in_range;
  assign arr_be    = sweeping ? {BE_W{1'b1}} : be;
  assign arr_addr  = sweeping ? cnt_q : addr;
  assign arr_wdata = sweeping ? INIT_VAL : din;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  // Out-of-range reads still raise valid; the array returns zero for them.
  logic v1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1_q <= 1'b0;
    else        v1_q <= rd_accept;
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rvalid = v1_q;
    assign dout   = arr_rdata;
  end else begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        d2_q <= arr_rdata;
      end
    end

    assign rvalid = v2_q;
    assign dout   = d2_q;
  end

endmodule
